// File: rtl/serial_adder_pkg.sv
// Shared state encoding and sizing/increment helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit-counter width: $clog2(w), never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : 32'($clog2(w));
    endfunction

    // Ripple increment, so the block's only adder is the full_adder cell.
    function automatic logic [63:0] incr(input logic [63:0] v);
        logic [63:0] r;
        logic        c;
        c = 1'b1;
        for (int i = 0; i < 64; i++) begin
            r[i] = v[i] ^ c;
            c    = v[i] & c;
        end
        return r;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell shared across all bit positions.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum and carry of three input bits.
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: LSB-first through one full_adder, W cycles per op.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int unsigned CW = cnt_width(W);

    state_t         state;
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic [W-1:0]   sum_sh;
    logic           c;
    logic [CW-1:0]  cnt;

    logic           fa_s;
    logic           fa_cout;
    logic [W:0]     sum_cat;
    logic [W-1:0]   sum_nxt;
    logic [CW-1:0]  cnt_inc;
    logic           last_bit;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (c),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB; the W+1 concat keeps this legal for W=1.
    assign sum_cat  = {fa_s, sum_sh};
    assign sum_nxt  = sum_cat[W:1];
    assign cnt_inc  = CW'(incr(64'(cnt)));
    assign last_bit = (cnt == CW'(W - 1));

    // Sequencer state, datapath shifters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            c      <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        c      <= cin;
                        cnt    <= '0;
                        sum_sh <= '0;
                        busy   <= 1'b1;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_sh <= sum_nxt;
                    c      <= fa_cout;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt_inc;
                    if (last_bit) begin
                        sum   <= sum_nxt;
                        cout  <= fa_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        c      <= cin;
                        cnt    <= '0;
                        sum_sh <= '0;
                        busy   <= 1'b1;
                        state  <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at W=8 and W=1.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;

    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for done on the W=8 instance and checks latency and result.
    task automatic wait_done8(input string tag, input logic [7:0] es, input logic ec);
        int n;
        n = 0;
        while (!done8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'd8);
        check({tag, "_busy_off"}, 64'(busy8), 64'd0);
        check({tag, "_sum"}, 64'(sum8), 64'(es));
        check({tag, "_cout"}, 64'(cout8), 64'(ec));
    endtask

    // One W=8 operation; ends on the negedge where done is high.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic [7:0] es, input logic ec);
        start8 = 1'b1; a8 = a; b8 = b; cin8 = cin;
        @(negedge clk);
        start8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~cin;
        check({tag, "_busy_on"}, 64'(busy8), 64'd1);
        wait_done8(tag, es, ec);
    endtask

    // One W=1 operation; result expected one cycle after accept.
    task automatic op1(input string tag, input logic a, input logic b, input logic cin,
                       input logic es, input logic ec);
        int n;
        start1 = 1'b1; a1 = a; b1 = b; cin1 = cin;
        @(negedge clk);
        start1 = 1'b0;
        check({tag, "_busy_on"}, 64'(busy1), 64'd1);
        n = 0;
        while (!done1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'd1);
        check({tag, "_sum"}, 64'(sum1), 64'(es));
        check({tag, "_cout"}, 64'(cout1), 64'(ec));
    endtask

    initial begin
        logic [8:0] exp9;
        logic [7:0] ra, rb;
        logic       rc;
        int         bcnt;
        bit         seen;

        rst_n = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_busy", 64'(busy8), 64'd0);
        check("rst_done", 64'(done8), 64'd0);
        check("rst_sum",  64'(sum8),  64'd0);
        check("rst_cout", 64'(cout8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic op, then done must drop and sum must hold in IDLE.
        op8("t5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        @(negedge clk);
        check("t5a3c_pulse", 64'(done8), 64'd0);
        check("t5a3c_hold",  64'(sum8),  64'h96);

        op8("tff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        op8("tffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        @(negedge clk);

        // Start held through RUN with changing operands: first operands win.
        start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy8) bcnt++;
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = ~cin8;
        end
        @(negedge clk);
        check("hold_busy_cycles", 64'(bcnt), 64'd8);
        check("hold_done", 64'(done8), 64'd1);
        check("hold_sum",  64'(sum8),  64'h33);
        check("hold_cout", 64'(cout8), 64'd0);
        start8 = 1'b0;
        @(negedge clk);
        check("hold_single_done", 64'(done8), 64'd0);
        check("hold_idle_busy",   64'(busy8), 64'd0);

        // Reset at bit 4 of RUN aborts with no done.
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy8), 64'd0);
        check("abort_done", 64'(done8), 64'd0);
        check("abort_sum",  64'(sum8),  64'd0);
        check("abort_cout", 64'(cout8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8) seen = 1'b1;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        op8("t0101", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
        @(negedge clk);

        // Back-to-back accept from DONE; old sum held until the new done.
        op8("b2b_first", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        check("b2b_busy", 64'(busy8), 64'd1);
        check("b2b_done_low", 64'(done8), 64'd0);
        check("b2b_sum_held", 64'(sum8), 64'h96);
        wait_done8("b2b_second", 8'h00, 1'b1);
        @(negedge clk);

        // Random operands against the reference a+b+cin.
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            exp9 = 9'(ra) + 9'(rb) + 9'(rc);
            op8($sformatf("rnd%0d", i), ra, rb, rc, exp9[7:0], exp9[8]);
            @(negedge clk);
        end

        // W=1 instance.
        op1("w1_111", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        op1("w1_100", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        op1("w1_110", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        op1("w1_000", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
